instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of all instruction addresses.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum wait for a memory response before a fault is reported; range 1-255.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising clock edge.
REQ-005 fetch_address  input  ADDRESS_WIDTH  instruction address to fetch, from the program-counter stage.
REQ-006 fetch_valid  input  1  fetch_address is valid and requests a fetch.
REQ-007 fetch_ready  output  1  unit accepts a fetch this cycle; a fetch transfers when fetch_valid and fetch_ready are both 1.
REQ-008 flush  input  1  discard any in-flight or held fetch (branch redirect).
REQ-009 memory_address  output  ADDRESS_WIDTH  word address presented to instruction memory.
REQ-010 memory_request  output  1  memory_address is valid.
REQ-011 memory_grant  input  1  memory accepted the request this cycle.
REQ-012 memory_response_valid  input  1  memory_response_data is valid this cycle.
REQ-013 memory_response_data  input  32  instruction word from memory.
REQ-014 instruction  output  32  fetched instruction word.
REQ-015 instruction_address  output  ADDRESS_WIDTH  address that the instruction came from.
REQ-016 instruction_valid  output  1  instruction, instruction_address and fault are valid.
REQ-017 instruction_ready  input  1  decode accepts the instruction; a transfer happens when instruction_valid and instruction_ready are both 1.
REQ-018 fault  output  2  fault code qualified by instruction_valid: 0 none, 1 misaligned, 2 timeout.

Function
REQ-019 The state machine SHALL have four states: IDLE, REQUEST, WAIT, HOLD.
REQ-020 IDLE: fetch_ready=1; on a fetch transfer with fetch_address[1:0]==0 -> latch the address, go to REQUEST.
REQ-021 IDLE: on a fetch transfer with fetch_address[1:0]!=0 -> no memory request, fault=1, instruction=0, go to HOLD next cycle.
REQ-022 REQUEST: memory_request=1 and memory_address=the latched address; when memory_grant=1 -> go to WAIT and clear the timeout counter.
REQ-023 WAIT: when memory_response_valid=1 -> capture the data, fault=0, go to HOLD.
REQ-024 WAIT: the counter increments once per cycle without a response; on reaching TIMEOUT_CYCLES -> instruction=0, fault=2, go to HOLD.
REQ-025 HOLD: instruction_valid=1 and outputs are held stable until instruction_ready=1.
REQ-026 HOLD with instruction_ready=1: fetch_ready=1 in the same cycle, so back-to-back transfers are allowed; with a new fetch transfer -> REQUEST (or HOLD if misaligned), otherwise -> IDLE.
REQ-027 fetch_ready SHALL be 0 in REQUEST and WAIT, and in HOLD while instruction_ready=0.
REQ-028 Minimum latency, with a grant in the same cycle and a response one cycle later: fetch transfer at cycle N -> instruction_valid at cycle N+3.
REQ-029 flush in REQUEST -> drop the request (memory_request=0 from the next cycle), go to IDLE.
REQ-030 flush in WAIT -> go to DRAIN behaviour: stay in WAIT, flag the response as discard, and on response or timeout -> IDLE with no instruction_valid.
REQ-031 flush in HOLD -> instruction_valid=0 from the next cycle, go to IDLE.
REQ-032 flush has priority over instruction_ready and over a simultaneous fetch transfer; the fetch is not accepted while fetch_ready is forced to 0 during flush.
REQ-033 Only one memory transaction SHALL be outstanding at any time.
REQ-034 memory_response_valid outside WAIT SHALL be ignored.

Reset
REQ-035 While reset=1 at a clock edge the state SHALL become IDLE, the counter and discard flag SHALL clear, and the outputs SHALL be: memory_request=0, instruction_valid=0, fetch_ready=0 during reset and 1 from the first cycle after, instruction=0, instruction_address=0, fault=0, memory_address=0.
REQ-036 Reset mid-transaction SHALL abandon it; a late response after reset SHALL be ignored.

Verification
REQ-037 Fetch 0x00000010, grant immediately, response 0x00A00093 one cycle later -> instruction_valid with instruction=0x00A00093, instruction_address=0x10, fault=0 at N+3.
REQ-038 Fetch 0x00000006 -> no memory_request, instruction_valid with fault=1 and instruction_address=0x6.
REQ-039 TIMEOUT_CYCLES=4, grant, no response -> fault=2 after 4 WAIT cycles; a later response is ignored.
REQ-040 Flush in WAIT, response arrives 3 cycles later -> no instruction_valid; next fetch 0x20 completes normally.
REQ-041 Hold instruction_ready=0 for 5 cycles in HOLD -> outputs stable and fetch_ready=0; then ready=1 with a new fetch in the same cycle -> memory_request asserted the next cycle.
REQ-042 Assert reset during REQUEST -> memory_request=0 and state IDLE the next cycle; all outputs at their reset values.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: program-counter request, instruction-memory port and decode handoff.
interface instruction_fetch_if #(
    parameter int unsigned ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] fetch_address;
    logic                     fetch_valid;
    logic                     fetch_ready;
    logic                     flush;
    logic [ADDRESS_WIDTH-1:0] memory_address;
    logic                     memory_request;
    logic                     memory_grant;
    logic                     memory_response_valid;
    logic [31:0]              memory_response_data;
    logic [31:0]              instruction;
    logic [ADDRESS_WIDTH-1:0] instruction_address;
    logic                     instruction_valid;
    logic                     instruction_ready;
    logic [1:0]               fault;

    modport slave (
        input  fetch_address, fetch_valid, flush, memory_grant,
               memory_response_valid, memory_response_data, instruction_ready,
        output fetch_ready, memory_address, memory_request,
               instruction, instruction_address, instruction_valid, fault
    );

    modport master (
        output fetch_address, fetch_valid, flush, memory_grant,
               memory_response_valid, memory_response_data, instruction_ready,
        input  fetch_ready, memory_address, memory_request,
               instruction, instruction_address, instruction_valid, fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: accepts word-aligned fetches, runs one instruction-memory
// transaction at a time and hands the word (or a fault) to decode.
module instruction_fetch #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                clock,
    input logic                reset,
    instruction_fetch_if.slave bus
);
    localparam int unsigned COUNT_WIDTH      = 8;
    localparam logic [1:0]  FAULT_NONE       = 2'd0;
    localparam logic [1:0]  FAULT_MISALIGNED = 2'd1;
    localparam logic [1:0]  FAULT_TIMEOUT    = 2'd2;

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT, HOLD} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] wait_count;
    logic                   discard;
    logic                   fetch_transfer;
    logic                   misaligned;
    logic                   timeout_hit;

    // Ready is combinational so a releasing HOLD can take the next fetch in the same cycle.
    assign bus.fetch_ready = !reset && !bus.flush &&
                             ((state == IDLE) || ((state == HOLD) && bus.instruction_ready));
    assign fetch_transfer  = bus.fetch_valid && bus.fetch_ready;
    assign misaligned      = (bus.fetch_address[1:0] != 2'b00);
    assign timeout_hit     = ((wait_count + COUNT_WIDTH'(1)) == COUNT_WIDTH'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            wait_count              <= '0;
            discard                 <= 1'b0;
            bus.memory_request      <= 1'b0;
            bus.memory_address      <= '0;
            bus.instruction_valid   <= 1'b0;
            bus.instruction         <= '0;
            bus.instruction_address <= '0;
            bus.fault               <= FAULT_NONE;
        end else begin
            case (state)
                IDLE: begin
                end
                REQUEST: begin
                    if (bus.memory_grant) begin
                        // A grant alongside flush is already at memory, so it is drained as a discard.
                        bus.memory_request <= 1'b0;
                        wait_count         <= '0;
                        discard            <= bus.flush;
                        state              <= WAIT;
                    end else if (bus.flush) begin
                        bus.memory_request <= 1'b0;
                        state              <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.memory_response_valid || timeout_hit) begin
                        discard <= 1'b0;
                        if (discard || bus.flush) begin
                            state <= IDLE;
                        end else begin
                            state                 <= HOLD;
                            bus.instruction_valid <= 1'b1;
                            bus.instruction       <= bus.memory_response_valid ? bus.memory_response_data : 32'd0;
                            bus.fault             <= bus.memory_response_valid ? FAULT_NONE : FAULT_TIMEOUT;
                        end
                    end else begin
                        wait_count <= wait_count + COUNT_WIDTH'(1);
                        if (bus.flush) begin
                            discard <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.flush || bus.instruction_ready) begin
                        bus.instruction_valid <= 1'b0;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // An accepted fetch overrides the choice above; it only occurs in IDLE or a releasing HOLD.
            if (fetch_transfer) begin
                bus.instruction_address <= ADDRESS_WIDTH'(bus.fetch_address);
                if (misaligned) begin
                    state                 <= HOLD;
                    bus.instruction_valid <= 1'b1;
                    bus.instruction       <= '0;
                    bus.fault             <= FAULT_MISALIGNED;
                end else begin
                    bus.memory_address <= ADDRESS_WIDTH'(bus.fetch_address);
                    bus.memory_request <= 1'b1;
                    state              <= REQUEST;
                end
            end
        end
    end
endmodule
